// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the block-RAM port arbiter: default widths,
// FSM state encoding and the {valid,id} owner codes.
package bram_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF   = 11;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned MAX_LOCK_DEF = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_R0   = 2'b10;
    localparam logic [1:0] OWNER_R1   = 2'b11;

    function automatic logic [1:0] owner_code(arb_state_e state);
        logic [1:0] code;
        code = OWNER_NONE;
        unique case (state)
            StOwn0:  code = OWNER_R0;
            StOwn1:  code = OWNER_R1;
            default: code = OWNER_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one block-RAM port: single-cycle accept, burst lock with forced
// release after MAX_LOCK grants, 1-cycle read return. Define ARB_ROUND_ROBIN_EN for round robin.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [1:0]        owner
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             last_winner_q, last_winner_d;
    logic             rvalid0_q, rvalid1_q;
    logic             contested;
    logic             win1;
    logic             cnt_at_limit;

    assign contested = req0 & req1;
    // lock_cnt counts grants already given in this burst; the grant that reaches MAX_LOCK releases
    assign cnt_at_limit = (lock_cnt_q == CNT_W'(MAX_LOCK - 1));

`ifdef ARB_ROUND_ROBIN_EN
    assign win1 = ~last_winner_q;
`else
    // Fixed priority, except that a forced release of an r0 burst yields one contested cycle
    logic force_r1_q, force_r1_d;
    assign win1 = force_r1_q;
`endif

    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        last_winner_d = last_winner_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
        force_r1_d    = force_r1_q;
`endif
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (contested) begin
                        gnt0 = ~win1;
                        gnt1 = win1;
`ifndef ARB_ROUND_ROBIN_EN
                        force_r1_d = 1'b0;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                    if (gnt0) begin
                        last_winner_d = 1'b0;
                        if (lock0) begin
                            state_d    = StOwn0;
                            lock_cnt_d = CNT_W'(1);
                        end
                    end
                    if (gnt1) begin
                        last_winner_d = 1'b1;
                        if (lock1) begin
                            state_d    = StOwn1;
                            lock_cnt_d = CNT_W'(1);
                        end
                    end
                end
                StOwn0: begin
                    gnt0          = req0;
                    last_winner_d = 1'b0;
                    if (req0 && lock0 && !cnt_at_limit) begin
                        lock_cnt_d = lock_cnt_q + CNT_W'(1);
                    end else begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
`ifndef ARB_ROUND_ROBIN_EN
                        if (req0 && lock0) force_r1_d = 1'b1;
`endif
                    end
                end
                StOwn1: begin
                    gnt1          = req1;
                    last_winner_d = 1'b1;
                    if (req1 && lock1 && !cnt_at_limit) begin
                        lock_cnt_d = lock_cnt_q + CNT_W'(1);
                    end else begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            lock_cnt_q    <= '0;
            last_winner_q <= 1'b1;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
            force_r1_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            last_winner_q <= last_winner_d;
            rvalid0_q     <= gnt0 & ~we0;
            rvalid1_q     <= gnt1 & ~we1;
`ifndef ARB_ROUND_ROBIN_EN
            force_r1_q    <= force_r1_d;
`endif
        end
    end

    assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
    assign ram_addr = gnt1 ? addr1 : addr0;
    assign ram_din  = gnt1 ? wdata1 : wdata0;

    // Gated by rst so a read in flight when reset arrives is never reported
    assign rvalid0 = rvalid0_q & ~rst;
    assign rvalid1 = rvalid1_q & ~rst;
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;
    assign owner   = owner_code(state_q);

    a_one_grant: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));

endmodule
